receiver_mul_arbiter: RTL and testbench
=======================================

# receiver_mul_arbiter

Round-robin arbiter and pipeline controller that shares one 17s×18s→34 signed multiplier instance (`receiver_mul_17s_18s_34_1_1`) among several receiver datapath requesters, e.g. matched-filter taps, Doppler mixer and AGC gain stages. It accepts operand pairs over valid/ready handshakes and registers operands into the multiplier. It captures the product and returns it, tagged with the requester index, over a backpressured result port. Sits between the receiver DSP stages and the single shared multiplier.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `A_WIDTH`, 17, operand A width, signed
- `B_WIDTH`, 18, operand B width, signed
- `P_WIDTH`, 34, product width, signed
- `ID_WIDTH`, 2, requester tag width, ≥ clog2(NUM_REQ)

Ports:
- `ap_clk`  in  1  sole clock, rising edge
- `ap_rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester operand valid
- `req_ready`  out  NUM_REQ  per-requester accept, one-hot or zero
- `req_a`  in  NUM_REQ*A_WIDTH  packed operand A, requester i at [i*A_WIDTH +: A_WIDTH]
- `req_b`  in  NUM_REQ*B_WIDTH  packed operand B, same packing
- `mul_din0`  out  A_WIDTH  to multiplier din0
- `mul_din1`  out  B_WIDTH  to multiplier din1
- `mul_dout`  in  P_WIDTH  from multiplier dout (combinational)
- `res_valid`  out  1  result valid
- `res_ready`  in  1  downstream accept
- `res_data`  out  P_WIDTH  signed product
- `res_id`  out  ID_WIDTH  index of originating requester

## Operation
- Two register stages.
  - S1 holds operands: `s1_valid`, `s1_a`, `s1_b`, `s1_id`. `mul_din0 = s1_a` and `mul_din1 = s1_b`.
  - S2 holds the result: `res_valid`, `res_data`, `res_id`.
- Stage advance:
  - `s2_free = !res_valid || res_ready`.
  - `s1_free = !s1_valid || s2_free`.
  - S2 loads `mul_dout`/`s1_id` when `s1_valid && s2_free`. Otherwise, if `res_ready`, S2 clears `res_valid`.
- Arbitration:
  - Rotating pointer `rr_ptr` (clog2(NUM_REQ) bits).
  - Grant goes to the first i with `req_valid[i]`, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - `req_ready[i] = grant[i] && s1_free`. This is combinational.
  - `req_ready` is all-zero when no request is valid or `s1_free` is 0.
- Transfer occurs when `req_valid[i] && req_ready[i]`.
  - S1 loads `req_a`/`req_b` slice i, sets `s1_id = i`, and sets `s1_valid = 1`.
  - `rr_ptr ← (i+1) mod NUM_REQ`.
- With no transfer: S1 clears `s1_valid` if `s2_free`, else holds. `rr_ptr` holds.
- Fairness: a continuously valid requester is accepted within NUM_REQ transfers.
- Arithmetic: the product is the low P_WIDTH bits of the two's-complement product. No saturation. (-2^16)·(-2^17) = 2^33 wraps to 34'h2_0000_0000.
- Requesters must hold `req_valid` and operands stable until accepted. The block does not check this.
- Reset, asynchronous and mid-operation: all in-flight operations are discarded.
  - `s1_valid`, `res_valid` and `rr_ptr` clear.
  - `s1_a`, `s1_b`, `s1_id`, `res_data` and `res_id` are 0.
  - Hence `mul_din0`, `mul_din1`, `res_data` and `res_id` read 0, and `req_ready` reads 0 while reset is asserted.

## Timing
- Latency: a transfer at edge k gives `res_valid = 1` with data after edge k+1.
- Throughput: 1 result per cycle when `res_ready` stays high.
- Backpressure:
  - With `res_ready = 0`, at most 2 operations are held (S1 + S2). `req_ready` then goes to 0 the same cycle both stages are full.
  - Once `res_ready` rises, `req_ready` may assert in that same cycle, because the free-slot logic is combinational through `res_ready`.
- Simultaneous events:
  - An S2 drain and an S1→S2 move happen in the same edge.
  - An S1→S2 move and a new request accept happen in the same edge. No bubble.
- `res_data`/`res_id` stay stable while `res_valid && !res_ready`.
- The multiplier path is combinational between S1 and S2 and adds no cycle.

## Test plan
- Single op: req0 with a=-3, b=5 → one cycle after acceptance, `res_valid=1`, `res_data=34'h3_FFFF_FFF1` (-15), `res_id=0`.
- Extremes: req2 with a=-65536, b=-131072 → `res_data=34'h2_0000_0000`, `res_id=2`. Then a=65535, b=131071 → `res_data=34'h1_FFFD_0001`.
- Round-robin: all 4 requesters valid continuously with `res_ready=1` → accept order 0,1,2,3,0,1; one result per cycle. With only req1 and req3 valid → 1,3,1,3.
- Backpressure: stream with `res_ready=0` for 4 cycles → exactly 2 accepts, then `req_ready=0`, `res_data` held. After release, all results arrive in order with correct ids; nothing is lost or duplicated.
- Reset mid-stream: assert `ap_rst_n=0` asynchronously with both stages full → immediately `res_valid=0`, `req_ready=0`, `mul_din0=0`, `mul_din1=0`. After release the first grant goes to the lowest-index valid requester (rr_ptr=0).
- Pointer wrap: NUM_REQ=4, only req3 valid, then req0 and req3 valid → grant req3 first; after that accept, req0 is granted next (pointer wraps 3→0).

Source files
------------

// File: rtl/receiver_mul_arbiter.sv
// Round-robin front end for one shared 17s x 18s -> 34 signed multiplier: picks a
// requester, registers its operands into the multiplier and returns the tagged product.
module receiver_mul_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 17,
  parameter int B_WIDTH  = 18,
  parameter int P_WIDTH  = 34,
  parameter int ID_WIDTH = 2
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic [A_WIDTH-1:0]         mul_din0,
  output logic [B_WIDTH-1:0]         mul_din1,
  input  logic [P_WIDTH-1:0]         mul_dout,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [P_WIDTH-1:0]         res_data,
  output logic [ID_WIDTH-1:0]        res_id
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Operand stage (S1)
  logic                s1_valid;
  logic [A_WIDTH-1:0]  s1_a;
  logic [B_WIDTH-1:0]  s1_b;
  logic [ID_WIDTH-1:0] s1_id;

  // Arbitration
  logic [PTR_W-1:0]    rr_ptr;
  logic                grant_any;
  logic [PTR_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0]  grant;
  logic [A_WIDTH-1:0]  grant_a;
  logic [B_WIDTH-1:0]  grant_b;

  logic s2_free;
  logic s1_free;
  logic xfer;

  // Pointer arithmetic modulo NUM_REQ, valid for non-power-of-two requester counts.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base,
                                               input int unsigned     off);
    int unsigned sum;
    sum = (32'(base) + off) % NUM_REQ;
    return PTR_W'(sum);
  endfunction

  // Free-slot chain is combinational through res_ready so a draining result
  // and a new accept share the same edge without a bubble.
  assign s2_free = !res_valid || res_ready;
  assign s1_free = !s1_valid || s2_free;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && req_valid[ptr_add(rr_ptr, k)]) begin
        grant_any = 1'b1;
        grant_idx = ptr_add(rr_ptr, k);
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign grant_a = req_a[grant_idx*A_WIDTH +: A_WIDTH];
  assign grant_b = req_b[grant_idx*B_WIDTH +: B_WIDTH];

  // Gated by reset so nothing is advertised as accepted while the pipe is held clear.
  assign req_ready = grant & {NUM_REQ{s1_free && ap_rst_n}};
  assign xfer      = grant_any && s1_free && ap_rst_n;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the S1->S2 move and new accept coexist cleanly.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      // NOTE: operand/data registers are reset too, not only the valids, so the
      // multiplier inputs and result bus read zero while reset is held.
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      rr_ptr   <= '0;
    end else if (xfer) begin
      s1_valid <= 1'b1;
      s1_a     <= grant_a;
      s1_b     <= grant_b;
      s1_id    <= ID_WIDTH'(grant_idx);
      rr_ptr   <= ptr_add(grant_idx, 1);
    end else if (s2_free) begin
      s1_valid <= 1'b0;
    end
  end

  assign mul_din0 = s1_a;
  assign mul_din1 = s1_b;

  // Result stage (S2): the multiplier is combinational between S1 and S2.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
    end else if (s1_valid && s2_free) begin
      res_valid <= 1'b1;
      res_data  <= mul_dout;
      res_id    <= s1_id;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  a_ready_onehot : assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    $onehot0(req_ready));

  a_res_stable : assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
    (res_valid && !res_ready) |=> (res_valid && $stable(res_data) && $stable(res_id)));

endmodule

// File: tb/tb_receiver_mul_arbiter.sv
// Self-checking bench for receiver_mul_arbiter: vector table, hand-written corner
// sequences, and a randomized run against a queue-based pipeline model.
module tb_receiver_mul_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int A_WIDTH  = 17;
  localparam int B_WIDTH  = 18;
  localparam int P_WIDTH  = 34;
  localparam int ID_WIDTH = 2;

  typedef struct {
    int                 id;
    logic [A_WIDTH-1:0] a;
    logic [B_WIDTH-1:0] b;
    logic [P_WIDTH-1:0] exp_p;
  } vec_t;

  typedef struct {
    logic [P_WIDTH-1:0] p;
    int                 id;
    int                 stamp;
  } op_t;

  logic                       ap_clk = 1'b0;
  logic                       ap_rst_n;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*A_WIDTH-1:0] req_a;
  logic [NUM_REQ*B_WIDTH-1:0] req_b;
  logic [A_WIDTH-1:0]         mul_din0;
  logic [B_WIDTH-1:0]         mul_din1;
  logic [P_WIDTH-1:0]         mul_dout;
  logic                       res_valid;
  logic                       res_ready;
  logic [P_WIDTH-1:0]         res_data;
  logic [ID_WIDTH-1:0]        res_id;

  int n_cmp = 0;
  int n_err = 0;

  vec_t vecs[8];
  op_t  bp_q[$];
  op_t  mpipe[$];
  int   order[8];
  int   seen_id[8];
  logic seen_valid[8];
  logic [P_WIDTH-1:0] seen_data[8];
  int   rr_all[6] = '{0, 1, 2, 3, 0, 1};
  int   rr_odd[4] = '{1, 3, 1, 3};

  always #5 ap_clk = ~ap_clk;

  // Stand-in for the shared multiplier instance.
  assign mul_dout = P_WIDTH'(longint'($signed(mul_din0)) * longint'($signed(mul_din1)));

  receiver_mul_arbiter #(
    .NUM_REQ (NUM_REQ),
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH),
    .P_WIDTH (P_WIDTH),
    .ID_WIDTH(ID_WIDTH)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .mul_din0 (mul_din0),
    .mul_din1 (mul_din1),
    .mul_dout (mul_dout),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_id   (res_id)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [P_WIDTH-1:0] prod(input logic [A_WIDTH-1:0] a,
                                              input logic [B_WIDTH-1:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return P_WIDTH'(sa * sb);
  endfunction

  function automatic logic [A_WIDTH-1:0] get_a(input int i);
    return req_a[i*A_WIDTH +: A_WIDTH];
  endfunction

  function automatic logic [B_WIDTH-1:0] get_b(input int i);
    return req_b[i*B_WIDTH +: B_WIDTH];
  endfunction

  task automatic set_op(input int i, input logic [A_WIDTH-1:0] a, input logic [B_WIDTH-1:0] b);
    req_a[i*A_WIDTH +: A_WIDTH] = a;
    req_b[i*B_WIDTH +: B_WIDTH] = b;
  endtask

  function automatic int accepted_idx();
    int r;
    r = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) r = i;
    end
    return r;
  endfunction

  function automatic logic [A_WIDTH-1:0] rnd_a();
    case ($urandom_range(0, 7))
      0:       return {1'b1, {(A_WIDTH-1){1'b0}}};
      1:       return {1'b0, {(A_WIDTH-1){1'b1}}};
      default: return A_WIDTH'($urandom);
    endcase
  endfunction

  function automatic logic [B_WIDTH-1:0] rnd_b();
    case ($urandom_range(0, 7))
      0:       return {1'b1, {(B_WIDTH-1){1'b0}}};
      1:       return {1'b0, {(B_WIDTH-1){1'b1}}};
      default: return B_WIDTH'($urandom);
    endcase
  endfunction

  // NOTE: inputs change only at the falling edge (blocking assignments) and
  // outputs are sampled there too, keeping clear of the active rising edge.
  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst_n  = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n  = 1'b1;
  endtask

  task automatic run_single(input vec_t v);
    req_valid       = '0;
    req_valid[v.id] = 1'b1;
    set_op(v.id, v.a, v.b);
    res_ready       = 1'b1;
    #1;
    check("vec_ready", 64'(req_ready), 64'(1) << v.id);
    @(posedge ap_clk);
    @(negedge ap_clk);
    req_valid = '0;
    #1;
    check("vec_din0", 64'(mul_din0), 64'(v.a));
    check("vec_din1", 64'(mul_din1), 64'(v.b));
    check("vec_not_yet_valid", 64'(res_valid), 64'(0));
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("vec_res_valid", 64'(res_valid), 64'(1));
    check("vec_res_data", 64'(res_data), 64'(v.exp_p));
    check("vec_res_id", 64'(res_id), 64'(v.id));
    @(posedge ap_clk);
    @(negedge ap_clk);
    check("vec_drained", 64'(res_valid), 64'(0));
  endtask

  task automatic collect_order(input logic [NUM_REQ-1:0] mask, input int n);
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, A_WIDTH'(i + 1), B_WIDTH'(3));
    req_valid = mask;
    res_ready = 1'b1;
    for (int c = 0; c < n; c++) begin
      #1;
      order[c]      = accepted_idx();
      seen_valid[c] = res_valid;
      seen_id[c]    = int'(res_id);
      seen_data[c]  = res_data;
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    req_valid = '0;
  endtask

  task automatic backpressure_seq();
    int n_acc;
    int g;
    int last_g;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, A_WIDTH'(100 + i), B_WIDTH'(-(i + 1)));
    req_valid = '1;
    res_ready = 1'b0;
    bp_q.delete();
    n_acc = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (c < 2) check("bp_grant", 64'(req_ready), 64'(1) << c);
      g = accepted_idx();
      if (g >= 0) begin
        n_acc++;
        bp_q.push_back('{prod(get_a(g), get_b(g)), g, 0});
      end
      if (c >= 2) begin
        check("bp_ready_zero", 64'(req_ready), 64'(0));
        check("bp_res_valid", 64'(res_valid), 64'(1));
        check("bp_held_data", 64'(res_data), 64'(prod(A_WIDTH'(100), B_WIDTH'(-1))));
        check("bp_held_id", 64'(res_id), 64'(0));
      end
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    check("bp_accept_count", 64'(n_acc), 64'(2));

    res_ready = 1'b1;
    last_g    = -1;
    for (int c = 0; c < 20; c++) begin
      if (c >= 1 && last_g >= 0) req_valid[last_g] = 1'b0;
      #1;
      if (c == 0) check("bp_release_ready", 64'(req_ready), 64'(4'b0100));
      if (res_valid) begin
        if (bp_q.size() == 0) begin
          check("bp_unexpected_result", 64'(res_valid), 64'(0));
        end else begin
          check("bp_order_data", 64'(res_data), 64'(bp_q[0].p));
          check("bp_order_id", 64'(res_id), 64'(bp_q[0].id));
          void'(bp_q.pop_front());
        end
      end
      g = accepted_idx();
      if (g >= 0) bp_q.push_back('{prod(get_a(g), get_b(g)), g, 0});
      // Release phase stops re-requesting: each requester drops after its next accept.
      last_g = (c >= 3) ? g : -1;
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    check("bp_nothing_lost", 64'(bp_q.size()), 64'(0));
    check("bp_idle_after", 64'(res_valid), 64'(0));
  endtask

  task automatic reset_midstream_seq();
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, A_WIDTH'(i + 2), B_WIDTH'(7));
    req_valid = '1;
    res_ready = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    @(posedge ap_clk);
    @(negedge ap_clk);
    #1;
    check("mid_pre_valid", 64'(res_valid), 64'(1));
    check("mid_pre_full", 64'(req_ready), 64'(0));
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("mid_rst_res_valid", 64'(res_valid), 64'(0));
    check("mid_rst_req_ready", 64'(req_ready), 64'(0));
    check("mid_rst_din0", 64'(mul_din0), 64'(0));
    check("mid_rst_din1", 64'(mul_din1), 64'(0));
    check("mid_rst_res_data", 64'(res_data), 64'(0));
    check("mid_rst_res_id", 64'(res_id), 64'(0));
    req_valid = 4'b1100;
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    #1;
    check("mid_first_grant", 64'(req_ready), 64'(4'b0100));
  endtask

  task automatic pointer_wrap_seq();
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, A_WIDTH'(i + 5), B_WIDTH'(2));
    req_valid = 4'b1000;
    res_ready = 1'b1;
    #1;
    check("wrap_grant3", 64'(req_ready), 64'(4'b1000));
    @(posedge ap_clk);
    @(negedge ap_clk);
    req_valid = 4'b1001;
    #1;
    check("wrap_grant0", 64'(req_ready), 64'(4'b0001));
    @(posedge ap_clk);
    @(negedge ap_clk);
    req_valid = '0;
  endtask

  // Model: ops wait in an ordered queue of at most two entries; the head is
  // visible one edge after its acceptance; a new op fits if the queue, after
  // this edge's drain, holds fewer than two.
  task automatic random_run(input int cycles);
    int rr;
    int g;
    int acc_id;
    int idx;
    logic presented;
    logic drain;
    logic accept;
    logic [A_WIDTH-1:0] last_a;
    logic [B_WIDTH-1:0] last_b;
    do_reset();
    mpipe.delete();
    rr     = 0;
    acc_id = -1;
    last_a = '0;
    last_b = '0;
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_id == i) begin
          if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
          else set_op(i, rnd_a(), rnd_b());
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          set_op(i, rnd_a(), rnd_b());
        end
      end
      res_ready = ($urandom_range(0, 3) != 0);
      #1;
      presented = (mpipe.size() > 0) && (mpipe[0].stamp <= c - 2);
      drain     = presented && res_ready;
      g = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (rr + k) % NUM_REQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
      accept = (g >= 0) && ((mpipe.size() - (drain ? 1 : 0)) < 2);
      check("rnd_req_ready", 64'(req_ready), accept ? (64'(1) << g) : 64'(0));
      check("rnd_res_valid", 64'(res_valid), 64'(presented));
      if (presented) begin
        check("rnd_res_data", 64'(res_data), 64'(mpipe[0].p));
        check("rnd_res_id", 64'(res_id), 64'(mpipe[0].id));
      end
      check("rnd_din0", 64'(mul_din0), 64'(last_a));
      check("rnd_din1", 64'(mul_din1), 64'(last_b));
      @(posedge ap_clk);
      acc_id = -1;
      if (drain) void'(mpipe.pop_front());
      if (accept) begin
        mpipe.push_back('{prod(get_a(g), get_b(g)), g, c});
        rr     = (g + 1) % NUM_REQ;
        last_a = get_a(g);
        last_b = get_b(g);
        acc_id = g;
      end
      @(negedge ap_clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{0, A_WIDTH'(-3),     B_WIDTH'(5),       34'h3_FFFF_FFF1};
    vecs[1] = '{2, A_WIDTH'(-65536), B_WIDTH'(-131072), 34'h2_0000_0000};
    vecs[2] = '{2, A_WIDTH'(65535),  B_WIDTH'(131071),  34'h1_FFFD_0001};
    vecs[3] = '{1, A_WIDTH'(-1),     B_WIDTH'(-1),      34'h0_0000_0001};
    vecs[4] = '{3, A_WIDTH'(-65536), B_WIDTH'(131071),  34'h2_0001_0000};
    vecs[5] = '{1, A_WIDTH'(65535),  B_WIDTH'(-131072), 34'h2_0002_0000};
    vecs[6] = '{3, A_WIDTH'(0),      B_WIDTH'(12345),   34'h0_0000_0000};
    vecs[7] = '{0, A_WIDTH'(7),      B_WIDTH'(9),       34'h0_0000_003F};

    // Reset state, with every requester valid to show req_ready is held low.
    ap_rst_n  = 1'b0;
    req_valid = '1;
    res_ready = 1'b1;
    req_a     = '1;
    req_b     = '1;
    #12;
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_data", 64'(res_data), 64'(0));
    check("rst_res_id", 64'(res_id), 64'(0));
    check("rst_din0", 64'(mul_din0), 64'(0));
    check("rst_din1", 64'(mul_din1), 64'(0));

    do_reset();
    for (int v = 0; v < 8; v++) run_single(vecs[v]);

    collect_order(4'b1111, 6);
    for (int c = 0; c < 6; c++) begin
      check("rr_all_order", 64'(order[c]), 64'(rr_all[c]));
      if (c >= 2) begin
        check("rr_all_res_valid", 64'(seen_valid[c]), 64'(1));
        check("rr_all_res_id", 64'(seen_id[c]), 64'(rr_all[c-2]));
        check("rr_all_res_data", 64'(seen_data[c]), 64'(3 * (rr_all[c-2] + 1)));
      end
    end

    collect_order(4'b1010, 4);
    for (int c = 0; c < 4; c++) check("rr_odd_order", 64'(order[c]), 64'(rr_odd[c]));

    backpressure_seq();
    reset_midstream_seq();
    pointer_wrap_seq();
    random_run(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
